fifo_write_arbiter: RTL
=======================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the write port of one linear synchronous FIFO among NUM_REQ producers.
//  Grants one producer at a time and forwards its words to the FIFO, bounded by MAX_BURST accepted words per grant.
//  Gates all writes on fifo_full, so no write is ever issued to a full FIFO.
//  Sits between producer blocks and the FIFO write side; the read side is untouched.
// PARAMETERS
//  NUM_REQ    4   number of producers, 2..8
//  DATA_W     4   word width, matches FIFO data_in
//  MAX_BURST  4   max accepted words per grant, 1..15
// PORTS
//  clk        in   1                 rising-edge clock
//  reset      in   1                 synchronous, active-low
//  req        in   NUM_REQ           producer i has a valid word on its data slice
//  req_data   in   NUM_REQ*DATA_W    producer i word at [i*DATA_W +: DATA_W]
//  grant      out  NUM_REQ           registered one-hot grant; all zero when idle
//  ack        out  NUM_REQ           word of producer i accepted this cycle
//  fifo_full  in   1                 FIFO full flag
//  fifo_wr_en out  1                 FIFO write enable
//  fifo_data  out  DATA_W            FIFO write data
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - state=IDLE, grant=0, rr_ptr=0, burst_cnt=0.
//   - ack, fifo_wr_en and fifo_data are therefore 0 in the following cycle.
//   - Mid-burst reset drops the grant at that edge; the partial burst is lost and no write is issued in the reset cycle.
//  Accept: acc = |(grant & req) & !fifo_full.
//   - fifo_wr_en = acc; ack = grant & {NUM_REQ{acc}}.
//   - fifo_data = slice of the granted index; 0 when grant==0. All three are combinational from registered state.
//  Producer rule: hold req and its data stable until ack. Dropping req before ack withdraws the word.
//  FSM IDLE:
//   - If no req, stay in IDLE.
//   - Otherwise, at the next edge, grant the first set req at or after rr_ptr (cyclic search) and go to BURST.
//   - Latency: req to first possible fifo_wr_en is 1 cycle.
//  FSM BURST (grant index g):
//   - On acc, burst_cnt++.
//   - Burst ends at an edge when either (a) acc and burst_cnt==MAX_BURST-1, or (b) req[g]==0.
//   - On end: rr_ptr=(g+1)%NUM_REQ and burst_cnt=0. The next grant is chosen at the same edge by cyclic search from the new rr_ptr, with no bubble. If no req remains, go to IDLE.
//   - fifo_full stall: grant is held and burst_cnt frozen; the burst does not end on full alone.
//  Simultaneous events:
//   - Grant is never preempted by a higher-index or lower-index request.
//   - A req rising in the same cycle the burst ends is eligible for that edge's arbitration.
//  Sole requester: after MAX_BURST words it is re-granted at the same edge, with no dead cycle.
//  Widths: burst_cnt is 4 bits; rr_ptr is $clog2(NUM_REQ) bits and wraps from NUM_REQ-1 to 0.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   - Adds output words_written [15:0].
//   - Increments on every fifo_wr_en and saturates at 16'hFFFF. Reset value 0.
//  ARB_STATS_EN undefined:
//   - Port and counter are absent.
//   - Arbitration behaviour is identical in both builds.
// TESTING
//  1 reset=0 for 2 clk, req=4'b1111 -> grant=0, fifo_wr_en=0 throughout reset.
//  2 req=4'b0100 only, fifo_full=0, held 10 cycles -> grant=4'b0100 from cycle 1.
//    fifo_wr_en high cycles 1..9, words in order; re-grant to 2 at burst boundaries with no gap.
//  3 req=4'b1011, MAX_BURST=4, fifo_full=0 -> grant order 0,1,3,0, each exactly 4 acks.
//    Exactly one fifo_wr_en per cycle, no idle cycle between grants.
//  4 grant=4'b0001, fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0, ack=0, grant unchanged.
//    Burst resumes and completes 4 words total after full clears.
//  5 grant=4'b0010, req[1] drops after 2 acks, req[2]=1 -> grant moves to 4'b0100 at next edge; rr_ptr=2.
//  6 reset=0 asserted mid-burst -> grant=0 next cycle, no write that cycle.
//    With ARB_STATS_EN: words_written=0; after 5 accepted words, words_written=5.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional ARB_STATS_EN adds a saturating words_written counter.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]               words_written
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] TOP = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]         burst_cnt_q, burst_cnt_d;

  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   g_next;
  logic [PTR_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic               g_req;
  logic               acc;
  logic               burst_end;

  // First set request at or after p, searching cyclically.
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [PTR_W-1:0]   p
  );
    logic [NUM_REQ-1:0] oh;
    int j;
    oh = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(p) + k) % NUM_REQ;
      if (r[j]) begin
        oh    = '0;
        oh[j] = 1'b1;
      end
    end
    return oh;
  endfunction

  // Index of the granted producer.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
  end

  // Write data mux; zero while idle.
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) fifo_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign grant      = grant_q;
  assign g_req      = |(grant_q & req);
  assign acc        = g_req & ~fifo_full;
  assign fifo_wr_en = acc;
  assign ack        = grant_q & {NUM_REQ{acc}};

  assign g_next    = (g_idx == TOP) ? '0 : g_idx + 1'b1;
  assign burst_end = (acc && burst_cnt_q == LAST) || !g_req;
  assign pick_ptr  = (state_q == S_BURST) ? g_next : rr_ptr_q;
  assign pick_oh   = rr_pick(req, pick_ptr);

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next grant: hold during a burst, rearbitrate with no bubble at its end.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|req) begin
          state_d = S_BURST;
          grant_d = pick_oh;
        end
      end
      S_BURST: begin
        if (burst_end) begin
          rr_ptr_d    = g_next;
          burst_cnt_d = '0;
          if (|req) begin
            grant_d = pick_oh;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else if (acc) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end
    endcase
  end

`ifdef ARB_STATS_EN
  // Saturating count of words written to the FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      words_written <= '0;
    end else if (fifo_wr_en && words_written != 16'hFFFF) begin
      words_written <= words_written + 16'd1;
    end
  end
`endif

endmodule
